svm_linear_multimodal: RTL and testbench
========================================

Name: svm_linear_multimodal

Overview:
- Parametrised successor to the two-modality SVM classifier.
- Classifies NUM_MOD feature vectors per entry, one linear-kernel SVM per modality (valence/arousal generalise to N), and returns all labels together in one output handshake.
- Weights and biases are runtime-loaded through a config port instead of fixed ROM.
- Dot products run over LANES parallel multipliers, so throughput is tunable against area.

Parameters:
- NBITS, 16: signed width of features, weights and biases.
- F_WIDTH, 32: features per vector. Must be a multiple of LANES.
- NUM_MOD, 2: modalities per entry.
- LANES, 4: MACs per cycle.
- ACC_BITS, 2*NBITS+ceilLog2(F_WIDTH)+1: signed score width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_we  in  1  config write strobe
- cfg_ready  out  1  config writes accepted
- cfg_mod  in  ceilLog2(NUM_MOD)  target modality
- cfg_addr  in  ceilLog2(F_WIDTH+1)  0..F_WIDTH-1 weight index; F_WIDTH = bias
- cfg_wdata  in  NBITS  signed weight or bias
- in_features  in  NBITS*F_WIDTH  feature j at [j*NBITS +: NBITS], signed
- fin_valid  in  1  feature vector valid
- fin_ready  out  1  vector accepted
- labels  out  NUM_MOD  bit m = class of modality m
- scores  out  NUM_MOD*ACC_BITS  decision value of modality m at [m*ACC_BITS +: ACC_BITS]
- dout_valid  out  1  labels/scores valid
- dout_ready  in  1  downstream accepts

Behaviour:
- Reset: one clock, synchronous, active-high (fixed). All outputs, state, modality counter m, lane counter, accumulator, weights and biases go to 0. A vector classified before any config load therefore scores 0 and gets label 1.
- FSM states: S_IDLE, S_MAC, S_BIAS, S_OUT.
  - S_IDLE: fin_ready=1. On fin_valid&&fin_ready, latch in_features, clear accumulator, set lane counter to 0, go to S_MAC. Later changes on in_features are ignored.
  - S_MAC: each cycle, acc += sum over l<LANES of w[m][k*LANES+l]*x[k*LANES+l], where k is the lane counter. Stays F_WIDTH/LANES cycles, then goes to S_BIAS.
  - S_BIAS: score[m] = acc + sign-extended bias[m]. labels[m] = (score >= 0); a tie at 0 gives 1. If m==NUM_MOD-1, go to S_OUT; else m++ and go to S_IDLE.
  - S_OUT: dout_valid=1. Hold labels, scores and state until dout_ready. On handshake, set m=0 and go to S_IDLE; dout_valid drops the next cycle.
- Modality order: the vector for modality 0 is always the first accepted after S_OUT or reset; the input supplies vectors in order 0..NUM_MOD-1.
- Latency: handshake in cycle t gives S_BIAS in cycle t+F_WIDTH/LANES+1. The next fin_ready (or dout_valid, for the last modality) comes one cycle later.
- fin_ready is 0 in S_MAC, S_BIAS and S_OUT. There is no input buffering and no back-to-back accept.
- Config:
  - cfg_ready = (state==S_IDLE && m==0 && !dout_valid).
  - Writes with cfg_we while cfg_ready=0 are dropped silently.
  - cfg_addr > F_WIDTH or cfg_mod >= NUM_MOD is ignored.
  - A write and a fin handshake in the same cycle: the write lands first, so the new value applies to that vector.
- Arithmetic: two's complement throughout. Products are 2*NBITS bits, sign-extended to ACC_BITS. ACC_BITS guarantees no overflow, so there is no saturation.
- labels and scores of earlier modalities update in S_BIAS and are meaningful only while dout_valid=1.
- Reset mid-operation (any state) aborts the entry: nothing is output, and weights are cleared.

Decomposition:
- Package svm_pkg holds:
  - ceilLog2 function
  - ACC_BITS derivation
  - state enum (S_IDLE, S_MAC, S_BIAS, S_OUT)
  - lane/modality counter width helpers
- Sub-module svm_dot_slice: LANES signed multipliers plus adder tree, producing the ACC_BITS partial sum. It is combinational and instantiated once.
- FSM, weight register file and accumulator stay in the top.

Test Plan (NBITS=16, F_WIDTH=8, LANES=4, NUM_MOD=2):
1. Reset: after rst, fin_ready=1, cfg_ready=1, dout_valid=0, labels=2'b00, scores=0. An unconfigured vector of all 7s gives score 0 and labels[0]=1.
2. Load mod0 weights all 1 with bias -10, and mod1 weights all -1 with bias 5. Send mod0 features all 2, then mod1 features all 2 → scores {-11, 6}, labels=2'b01. dout_valid 4 cycles after the mod1 handshake; fin_ready rises 4 cycles after the mod0 handshake.
3. Backpressure: hold dout_ready=0 for 5 cycles in S_OUT → dout_valid, labels and scores stable, fin_ready=0, cfg_ready=0. Raise dout_ready → dout_valid=0 next cycle, then a mod0 vector is accepted.
4. Tie: weights 0, bias 0 → score 0, label 1. Bias -1 → label 0.
5. Extremes: all weights and features -32768, bias 0 → score 2^33 = 36'h200000000, label 1, with no wrap.
6. Reset during S_MAC of mod1 → next cycle fin_ready=1, m=0, dout_valid=0, weights cleared. A cfg write with cfg_we during S_MAC is dropped, so the score is unchanged.

Source files
------------

// File: rtl/svm_pkg.sv
// Shared types and sizing helpers for the multimodal linear SVM.
package svm_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_BIAS,
    S_OUT
  } state_t;

  function automatic int ceilLog2(input int v);
    int r;
    r = 0;
    while ((32'sd1 <<< r) < v) r++;
    return r;
  endfunction

  function automatic int acc_bits(input int nbits, input int fw);
    return 2 * nbits + ceilLog2(fw) + 1;
  endfunction

  // Counter width, never narrower than one bit.
  function automatic int cnt_w(input int v);
    return (v > 1) ? ceilLog2(v) : 1;
  endfunction

endpackage

// File: rtl/svm_dot_slice.sv
// LANES signed multipliers summed into one ACC_BITS partial dot product.
module svm_dot_slice #(
  parameter int NBITS    = 16,
  parameter int LANES    = 4,
  parameter int ACC_BITS = 38
) (
  input  logic [LANES*NBITS-1:0] w_lanes,
  input  logic [LANES*NBITS-1:0] x_lanes,
  output logic [ACC_BITS-1:0]    sum
);

  logic signed [2*NBITS-1:0] prod [LANES];

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      prod[l] = (2*NBITS)'(signed'(w_lanes[l*NBITS +: NBITS]))
              * (2*NBITS)'(signed'(x_lanes[l*NBITS +: NBITS]));
    end
  end

  always_comb begin
    sum = '0;
    for (int l = 0; l < LANES; l++) begin
      sum = sum + ACC_BITS'(prod[l]);
    end
  end

endmodule

// File: rtl/svm_linear_multimodal.sv
// Runtime-configurable linear SVM, one classifier per modality,
// all labels returned together once the last modality is scored.
module svm_linear_multimodal
  import svm_pkg::*;
#(
  parameter int NBITS    = 16,
  parameter int F_WIDTH  = 32,
  parameter int NUM_MOD  = 2,
  parameter int LANES    = 4,
  parameter int ACC_BITS = acc_bits(NBITS, F_WIDTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_we,
  output logic                        cfg_ready,
  input  logic [cnt_w(NUM_MOD)-1:0]   cfg_mod,
  input  logic [cnt_w(F_WIDTH+1)-1:0] cfg_addr,
  input  logic [NBITS-1:0]            cfg_wdata,
  input  logic [NBITS*F_WIDTH-1:0]    in_features,
  input  logic                        fin_valid,
  output logic                        fin_ready,
  output logic [NUM_MOD-1:0]          labels,
  output logic [NUM_MOD*ACC_BITS-1:0] scores,
  output logic                        dout_valid,
  input  logic                        dout_ready
);

  localparam int MW     = cnt_w(NUM_MOD);
  localparam int AW     = cnt_w(F_WIDTH + 1);
  localparam int KSTEPS = F_WIDTH / LANES;
  localparam int KW     = cnt_w(KSTEPS);

  state_t state, state_nxt;

  logic [MW-1:0] m;
  logic [KW-1:0] k;

  logic signed [ACC_BITS-1:0] acc;
  logic signed [ACC_BITS-1:0] part;
  logic signed [ACC_BITS-1:0] score_c;

  logic [F_WIDTH-1:0][NBITS-1:0] x_q;
  logic [F_WIDTH-1:0][NBITS-1:0] w_q [NUM_MOD];
  logic [NBITS-1:0]              b_q [NUM_MOD];

  logic [LANES*NBITS-1:0] w_lanes;
  logic [LANES*NBITS-1:0] x_lanes;
  logic [NBITS-1:0]       b_sel;

  logic fin_fire;
  logic last_k;
  logic last_m;

  assign fin_ready  = (state == S_IDLE);
  assign dout_valid = (state == S_OUT);
  assign cfg_ready  = (state == S_IDLE) && (m == '0) && !dout_valid;
  assign fin_fire   = fin_valid && fin_ready;
  assign last_k     = (k == KW'(KSTEPS - 1));
  assign last_m     = (m == MW'(NUM_MOD - 1));

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (fin_fire) state_nxt = S_MAC;
      S_MAC:  if (last_k) state_nxt = S_BIAS;
      S_BIAS: state_nxt = last_m ? S_OUT : S_IDLE;
      S_OUT:  if (dout_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Lane and modality operand muxes for the current MAC step.
  always_comb begin
    w_lanes = '0;
    x_lanes = '0;
    b_sel   = '0;
    for (int mm = 0; mm < NUM_MOD; mm++) begin
      if (m == MW'(mm)) begin
        b_sel = b_q[mm];
        for (int kk = 0; kk < KSTEPS; kk++) begin
          if (k == KW'(kk)) w_lanes = w_q[mm][kk*LANES +: LANES];
        end
      end
    end
    for (int kk = 0; kk < KSTEPS; kk++) begin
      if (k == KW'(kk)) x_lanes = x_q[kk*LANES +: LANES];
    end
  end

  svm_dot_slice #(
    .NBITS    (NBITS),
    .LANES    (LANES),
    .ACC_BITS (ACC_BITS)
  ) u_dot (
    .w_lanes (w_lanes),
    .x_lanes (x_lanes),
    .sum     (part)
  );

  assign score_c = acc + ACC_BITS'(signed'(b_sel));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      m      <= '0;
      k      <= '0;
      acc    <= '0;
      x_q    <= '0;
      labels <= '0;
      scores <= '0;
      for (int mm = 0; mm < NUM_MOD; mm++) begin
        w_q[mm] <= '0;
        b_q[mm] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (cfg_we && cfg_ready) begin
        for (int mm = 0; mm < NUM_MOD; mm++) begin
          if (cfg_mod == MW'(mm)) begin
            for (int j = 0; j < F_WIDTH; j++) begin
              if (cfg_addr == AW'(j)) w_q[mm][j] <= cfg_wdata;
            end
            if (cfg_addr == AW'(F_WIDTH)) b_q[mm] <= cfg_wdata;
          end
        end
      end
      if (fin_fire) begin
        x_q <= in_features;
        acc <= '0;
        k   <= '0;
      end
      if (state == S_MAC) begin
        acc <= acc + part;
        if (!last_k) k <= k + KW'(1);
      end
      if (state == S_BIAS) begin
        for (int mm = 0; mm < NUM_MOD; mm++) begin
          if (m == MW'(mm)) begin
            scores[mm*ACC_BITS +: ACC_BITS] <= score_c;
            labels[mm] <= ~score_c[ACC_BITS-1];
          end
        end
        if (!last_m) m <= m + MW'(1);
      end
      if (dout_valid && dout_ready) m <= '0;
    end
  end

endmodule

// File: tb/tb_svm_linear_multimodal.sv
// Directed-vector bench for svm_linear_multimodal (F_WIDTH=8, LANES=4).
module tb_svm_linear_multimodal;

  localparam int NBITS   = 16;
  localparam int F_WIDTH = 8;
  localparam int NUM_MOD = 2;
  localparam int LANES   = 4;
  localparam int ACC     = 36;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     cfg_we = 1'b0;
  logic                     cfg_ready;
  logic [0:0]               cfg_mod = '0;
  logic [3:0]               cfg_addr = '0;
  logic [NBITS-1:0]         cfg_wdata = '0;
  logic [NBITS*F_WIDTH-1:0] in_features = '0;
  logic                     fin_valid = 1'b0;
  logic                     fin_ready;
  logic [NUM_MOD-1:0]       labels;
  logic [NUM_MOD*ACC-1:0]   scores;
  logic                     dout_valid;
  logic                     dout_ready = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  svm_linear_multimodal #(
    .NBITS   (NBITS),
    .F_WIDTH (F_WIDTH),
    .NUM_MOD (NUM_MOD),
    .LANES   (LANES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_ready   (cfg_ready),
    .cfg_mod     (cfg_mod),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .in_features (in_features),
    .fin_valid   (fin_valid),
    .fin_ready   (fin_ready),
    .labels      (labels),
    .scores      (scores),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] got,
                     input logic [79:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] sc(input longint s1, input longint s0);
    logic [35:0] a;
    logic [35:0] b;
    a = s1[35:0];
    b = s0[35:0];
    return {a, b};
  endfunction

  task automatic cfg_write(input int md, input int addr, input int val);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_mod   = md[0:0];
    cfg_addr  = addr[3:0];
    cfg_wdata = val[15:0];
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  task automatic cfg_all(input int md, input int w, input int b);
    for (int i = 0; i < F_WIDTH; i++) cfg_write(md, i, w);
    cfg_write(md, F_WIDTH, b);
  endtask

  // Returns #1 after the accepting edge.
  task automatic send_vec(input int v);
    logic [15:0] e;
    int n;
    e = v[15:0];
    @(negedge clk);
    in_features = {F_WIDTH{e}};
    fin_valid = 1'b1;
    n = 0;
    while (!fin_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) chk("accept_timeout", 80'(fin_ready), 80'd1);
    @(posedge clk);
    #1 fin_valid = 1'b0;
  endtask

  task automatic wait_dout();
    int n;
    n = 0;
    @(negedge clk);
    while (!dout_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) chk("dout_timeout", 80'(dout_valid), 80'd1);
  endtask

  task automatic release_out();
    @(negedge clk);
    dout_ready = 1'b1;
    @(posedge clk);
    #1 dout_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and an unconfigured entry
    @(negedge clk);
    chk("rst_fin_ready", 80'(fin_ready), 80'd1);
    chk("rst_cfg_ready", 80'(cfg_ready), 80'd1);
    chk("rst_dout_valid", 80'(dout_valid), 80'd0);
    chk("rst_labels", 80'(labels), 80'd0);
    chk("rst_scores", 80'(scores), 80'd0);
    send_vec(7);
    send_vec(7);
    wait_dout();
    chk("uncfg_scores", 80'(scores), 80'(sc(0, 0)));
    chk("uncfg_labels", 80'(labels), 80'b11);
    release_out();

    // Basic classification with latency checks
    cfg_all(0, 1, -10);
    cfg_all(1, -1, 5);
    send_vec(2);
    repeat (3) @(negedge clk);
    chk("m0_fin_ready_early", 80'(fin_ready), 80'd0);
    @(negedge clk);
    chk("m0_fin_ready_t4", 80'(fin_ready), 80'd1);
    send_vec(2);
    repeat (3) @(negedge clk);
    chk("m1_dout_early", 80'(dout_valid), 80'd0);
    @(negedge clk);
    chk("m1_dout_t4", 80'(dout_valid), 80'd1);
    chk("basic_scores", 80'(scores), 80'(sc(-11, 6)));
    chk("basic_labels", 80'(labels), 80'b01);

    // Backpressure hold
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 80'(dout_valid), 80'd1);
      chk("bp_scores", 80'(scores), 80'(sc(-11, 6)));
      chk("bp_labels", 80'(labels), 80'b01);
      chk("bp_fin_ready", 80'(fin_ready), 80'd0);
      chk("bp_cfg_ready", 80'(cfg_ready), 80'd0);
    end
    release_out();
    @(negedge clk);
    chk("bp_drop_valid", 80'(dout_valid), 80'd0);
    chk("bp_fin_ready", 80'(fin_ready), 80'd1);
    chk("bp_cfg_ready_back", 80'(cfg_ready), 80'd1);
    send_vec(2);
    @(negedge clk);
    chk("bp_accepted", 80'(fin_ready), 80'd0);
    send_vec(2);
    wait_dout();
    chk("bp2_scores", 80'(scores), 80'(sc(-11, 6)));
    chk("bp2_labels", 80'(labels), 80'b01);
    release_out();

    // Tie at zero and just below
    cfg_all(0, 0, 0);
    cfg_all(1, 0, -1);
    send_vec(9);
    send_vec(9);
    wait_dout();
    chk("tie_scores", 80'(scores), 80'(sc(-1, 0)));
    chk("tie_labels", 80'(labels), 80'b01);
    release_out();

    // Most negative operands, no wrap
    cfg_all(0, -32768, 0);
    cfg_all(1, -32768, 0);
    send_vec(-32768);
    send_vec(-32768);
    wait_dout();
    chk("ext_scores", 80'(scores),
        80'(sc(64'sh200000000, 64'sh200000000)));
    chk("ext_labels", 80'(labels), 80'b11);
    release_out();

    // Config write during MAC is dropped
    cfg_all(0, 1, 0);
    cfg_all(1, 1, 0);
    send_vec(3);
    cfg_we = 1'b1;
    cfg_mod = 1'b0;
    cfg_addr = 4'd8;
    cfg_wdata = 16'd100;
    @(posedge clk);
    #1 cfg_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    send_vec(3);
    cfg_we = 1'b1;
    cfg_mod = 1'b1;
    cfg_addr = 4'd0;
    cfg_wdata = 16'd50;
    @(posedge clk);
    #1 cfg_we = 1'b0;
    wait_dout();
    chk("drop_scores", 80'(scores), 80'(sc(24, 24)));
    chk("drop_labels", 80'(labels), 80'b11);
    release_out();

    // Reset during mod1 MAC
    send_vec(3);
    send_vec(3);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mrst_fin_ready", 80'(fin_ready), 80'd1);
    chk("mrst_cfg_ready", 80'(cfg_ready), 80'd1);
    chk("mrst_dout_valid", 80'(dout_valid), 80'd0);
    chk("mrst_scores", 80'(scores), 80'd0);
    chk("mrst_labels", 80'(labels), 80'd0);
    send_vec(5);
    send_vec(5);
    wait_dout();
    chk("mrst_cleared_scores", 80'(scores), 80'(sc(0, 0)));
    chk("mrst_cleared_labels", 80'(labels), 80'b11);
    release_out();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
